// File: rtl/ra_pq.sv
// Register-array priority queue: flat slot registers with per-slot valid bits and a
// combinational min-key selector; enq, deq or replace each complete in one cycle.
module ra_pq #(
   parameter int PQ_CAPACITY = 16,
   parameter int KEY_WIDTH   = 8,
   parameter int VAL_WIDTH   = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enq_i,
   input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi_i,
   input  logic                           deq_i,
   output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic                           busy_o
);

   localparam int KV_W  = KEY_WIDTH + VAL_WIDTH;
   localparam int IDX_W = $clog2(PQ_CAPACITY);

   logic [KV_W-1:0]        slot_q [PQ_CAPACITY];
   logic [PQ_CAPACITY-1:0] valid_q, valid_d;

   logic [IDX_W-1:0]     head_idx, free_idx, wr_idx;
   logic [KEY_WIDTH-1:0] head_key;
   logic                 head_hit, wr_en;

   assign full_o  = &valid_q;
   assign empty_o = ~|valid_q;
   assign busy_o  = 1'b0;

   // Strict less-than while scanning upward keeps ties on the lowest slot index.
   always_comb begin
      head_idx = '0;
      head_key = '0;
      head_hit = 1'b0;
      for (int i = 0; i < PQ_CAPACITY; i++) begin
         if (valid_q[i] && (!head_hit || slot_q[i][KV_W-1:VAL_WIDTH] < head_key)) begin
            head_hit = 1'b1;
            head_key = slot_q[i][KV_W-1:VAL_WIDTH];
            head_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      free_idx = '0;
      for (int i = PQ_CAPACITY - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = IDX_W'(i);
      end
   end

   // Replace overwrites the head in place, so it stays legal when the array is full.
   always_comb begin
      valid_d = valid_q;
      wr_en   = 1'b0;
      wr_idx  = free_idx;
      if (enq_i && deq_i && !empty_o) begin
         wr_en  = 1'b1;
         wr_idx = head_idx;
      end else if (enq_i && !full_o) begin
         wr_en             = 1'b1;
         valid_d[free_idx] = 1'b1;
      end else if (deq_i && !empty_o) begin
         valid_d[head_idx] = 1'b0;
      end
   end

   assign kvo_o = empty_o ? '0 : slot_q[head_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // Slot payload is qualified by valid_q, so it carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en) slot_q[wr_idx] <= kvi_i;
   end

endmodule

// File: tb/tb_ra_pq.sv
// Self-checking bench for ra_pq: directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_ra_pq;

   localparam int CAP = 16;
   localparam int KW  = 8;
   localparam int VW  = 8;
   localparam int W   = KW + VW;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enq = 1'b0;
   logic         deq = 1'b0;
   logic [W-1:0] kvi = '0;
   logic [W-1:0] kvo;
   logic         full, empty, busy;

   int vecs = 0;
   int errs = 0;

   logic [W-1:0] mq [$];

   ra_pq #(.PQ_CAPACITY(CAP), .KEY_WIDTH(KW), .VAL_WIDTH(VW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enq_i  (enq),
      .kvi_i  (kvi),
      .deq_i  (deq),
      .kvo_o  (kvo),
      .full_o (full),
      .empty_o(empty),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mk(input int key, input int val);
      logic [W-1:0] r;
      r = {KW'(key), VW'(val)};
      return r;
   endfunction

   function automatic int model_min_pos();
      int p = 0;
      for (int i = 1; i < mq.size(); i++)
         if (mq[i][W-1:VW] < mq[p][W-1:VW]) p = i;
      return p;
   endfunction

   function automatic logic [W-1:0] model_head();
      if (mq.size() == 0) return '0;
      return mq[model_min_pos()];
   endfunction

   function automatic void model_apply(input bit e, input bit d, input logic [W-1:0] kv);
      if (e && d && mq.size() > 0) begin
         mq.delete(model_min_pos());
         mq.push_back(kv);
      end else if (e && mq.size() < CAP) begin
         mq.push_back(kv);
      end else if (d && mq.size() > 0) begin
         mq.delete(model_min_pos());
      end
   endfunction

   // Drives one request mid-cycle, lets one rising edge take it, then returns #1 after it.
   task automatic op(input bit e, input bit d, input logic [W-1:0] kv);
      enq = e; deq = d; kvi = kv;
      model_apply(e, d, kv);
      @(posedge clk);
      #1;
      enq = 1'b0; deq = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      mq.delete();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) op(1, 0, mk(20 + i, i));
      vecs++;
      if (empty !== 1'b0) begin errs++; $display("FAIL reset_pre_empty got %b exp 0", empty); end
      rst_n = 1'b0;
      mq.delete();
      #2;
      vecs++;
      if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b exp 1", empty); end
      vecs++;
      if (full !== 1'b0) begin errs++; $display("FAIL reset_full got %b exp 0", full); end
      vecs++;
      if (kvo !== '0) begin errs++; $display("FAIL reset_kvo got %h exp 0", kvo); end
      vecs++;
      if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      op(0, 1, '0);
      vecs++;
      if (empty !== 1'b1 || kvo !== '0) begin
         errs++; $display("FAIL reset_deq_after got empty=%b kvo=%h exp empty=1 kvo=0", empty, kvo);
      end
   endtask

   task automatic test_sort();
      int keys [5] = '{9, 3, 7, 1, 5};
      int heads[5] = '{9, 3, 3, 1, 1};
      int order[5] = '{1, 3, 5, 7, 9};
      for (int i = 0; i < 5; i++) begin
         op(1, 0, mk(keys[i], keys[i] + 100));
         vecs++;
         if (kvo[W-1:VW] !== KW'(heads[i])) begin
            errs++; $display("FAIL sort_head[%0d] got %0d exp %0d", i, kvo[W-1:VW], heads[i]);
         end
      end
      for (int i = 0; i < 5; i++) begin
         vecs++;
         if (kvo !== mk(order[i], order[i] + 100)) begin
            errs++; $display("FAIL sort_deq[%0d] got key=%0d val=%0d exp key=%0d val=%0d",
                             i, kvo[W-1:VW], kvo[VW-1:0], order[i], order[i] + 100);
         end
         op(0, 1, '0);
      end
      vecs++;
      if (empty !== 1'b1) begin errs++; $display("FAIL sort_empty got %b exp 1", empty); end
   endtask

   task automatic test_full();
      for (int k = 15; k >= 0; k--) op(1, 0, mk(k, k));
      vecs++;
      if (full !== 1'b1 || kvo[W-1:VW] !== 8'd0) begin
         errs++; $display("FAIL full_flag got full=%b key=%0d exp full=1 key=0", full, kvo[W-1:VW]);
      end
      op(1, 0, mk(200, 200));
      vecs++;
      if (full !== 1'b1) begin errs++; $display("FAIL overflow_full got %b exp 1", full); end
      for (int i = 0; i < 16; i++) begin
         vecs++;
         if (kvo[W-1:VW] !== KW'(i)) begin
            errs++; $display("FAIL full_deq[%0d] got %0d exp %0d", i, kvo[W-1:VW], i);
         end
         op(0, 1, '0);
      end
      vecs++;
      if (empty !== 1'b1) begin errs++; $display("FAIL overflow_drain got empty=%b exp 1", empty); end
   endtask

   task automatic test_replace();
      op(1, 0, mk(4, 0));
      op(1, 0, mk(8, 0));
      op(1, 1, mk(6, 0));
      vecs++;
      if (kvo[W-1:VW] !== 8'd6) begin errs++; $display("FAIL replace6 got %0d exp 6", kvo[W-1:VW]); end
      op(1, 1, mk(2, 0));
      vecs++;
      if (kvo[W-1:VW] !== 8'd2) begin errs++; $display("FAIL replace2 got %0d exp 2", kvo[W-1:VW]); end
      op(0, 1, '0);
      vecs++;
      if (empty !== 1'b0 || kvo[W-1:VW] !== 8'd8) begin
         errs++; $display("FAIL replace_occ1 got empty=%b key=%0d exp empty=0 key=8", empty, kvo[W-1:VW]);
      end
      op(0, 1, '0);
      vecs++;
      if (empty !== 1'b1) begin errs++; $display("FAIL replace_occ2 got empty=%b exp 1", empty); end
   endtask

   task automatic test_full_replace();
      for (int i = 0; i < 16; i++) op(1, 0, mk(10 + ((i * 7) % 16), i));
      vecs++;
      if (full !== 1'b1 || kvo[W-1:VW] !== 8'd10) begin
         errs++; $display("FAIL fullrep_pre got full=%b key=%0d exp full=1 key=10", full, kvo[W-1:VW]);
      end
      op(1, 1, mk(255, 1));
      vecs++;
      if (full !== 1'b1 || kvo[W-1:VW] !== 8'd11) begin
         errs++; $display("FAIL fullrep got full=%b key=%0d exp full=1 key=11", full, kvo[W-1:VW]);
      end
      do_reset();
   endtask

   task automatic test_empty_edges();
      op(0, 1, '0);
      vecs++;
      if (empty !== 1'b1 || kvo !== '0) begin
         errs++; $display("FAIL empty_deq got empty=%b kvo=%h exp empty=1 kvo=0", empty, kvo);
      end
      op(1, 1, mk(42, 7));
      vecs++;
      if (empty !== 1'b0 || kvo !== mk(42, 7)) begin
         errs++; $display("FAIL empty_replace got empty=%b kvo=%h exp empty=0 kvo=%h", empty, kvo, mk(42, 7));
      end
      op(0, 1, '0);
      vecs++;
      if (empty !== 1'b1) begin errs++; $display("FAIL empty_replace_drain got %b exp 1", empty); end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_kv;
      bit e, d;
      for (int n = 0; n < 2000; n++) begin
         exp_kv = model_head();
         vecs++;
         if (kvo[W-1:VW] !== exp_kv[W-1:VW] || empty !== (mq.size() == 0) || full !== (mq.size() == CAP)) begin
            errs++;
            $display("FAIL rand[%0d] got key=%0d empty=%b full=%b exp key=%0d empty=%b full=%b",
                     n, kvo[W-1:VW], empty, full, exp_kv[W-1:VW], mq.size() == 0, mq.size() == CAP);
         end
         // Bias phases so the run spends time near both empty and full.
         if ((n / 200) % 2 == 0) begin
            e = ($urandom_range(0, 99) < 65); d = ($urandom_range(0, 99) < 40);
         end else begin
            e = ($urandom_range(0, 99) < 40); d = ($urandom_range(0, 99) < 65);
         end
         op(e, d, mk($urandom_range(0, 31), $urandom_range(0, 255)));
      end
   endtask

   initial begin
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_sort();
      test_full();
      test_replace();
      test_full_replace();
      test_empty_edges();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
